// File: rtl/dlx_mem_access_unit.sv
// ============================================================================
// Module   : dlx_mem_access_unit
// Purpose  : DLX MEM-stage load/store unit in front of a word-addressed RAM.
//            Handles big-endian sub-word loads and read-modify-write stores.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dlx_mem_access_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic [4:0]  resp_rd_o,
    output logic        resp_err_o,
    output logic [31:0] ram_adr_o,
    output logic        ram_we_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [4:0]  rd_q;

    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        is_load_q;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    // Alignment and range are judged on the live request, since that is
    // what gets latched on the accept edge.
    always_comb begin
        misaligned = 1'b0;
        unique case (req_op_i)
            OP_LH, OP_LHU, OP_SH: misaligned = req_addr_i[0];
            OP_LW, OP_SW:         misaligned = (req_addr_i[1:0] != 2'b00);
            default:              misaligned = 1'b0;
        endcase
        out_of_range = ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS));
        req_err      = misaligned | out_of_range;
    end

    assign is_load_q = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_LH) ||
                       (op_q == OP_LHU) || (op_q == OP_LW);

    // Big-endian lane select: offset 0 is the most significant byte.
    always_comb begin
        logic [7:0]  byte_lane;
        logic [15:0] half_lane;
        unique case (off_q)
            2'd0:    byte_lane = ram_rdata_i[31:24];
            2'd1:    byte_lane = ram_rdata_i[23:16];
            2'd2:    byte_lane = ram_rdata_i[15:8];
            default: byte_lane = ram_rdata_i[7:0];
        endcase
        half_lane = off_q[1] ? ram_rdata_i[15:0] : ram_rdata_i[31:16];
        unique case (op_q)
            OP_LB:   load_value = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_value = {24'h0, byte_lane};
            OP_LH:   load_value = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_value = {16'h0, half_lane};
            default: load_value = ram_rdata_i;
        endcase
    end

    always_comb begin
        merged_word = ram_rdata_i;
        if (op_q == OP_SB) begin
            unique case (off_q)
                2'd0:    merged_word[31:24] = wdata_q[7:0];
                2'd1:    merged_word[23:16] = wdata_q[7:0];
                2'd2:    merged_word[15:8]  = wdata_q[7:0];
                default: merged_word[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged_word[15:0] = wdata_q;
        end else begin
            merged_word[31:16] = wdata_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            op_q         <= OP_LB;
            off_q        <= 2'd0;
            wdata_q      <= 16'h0;
            rd_q         <= 5'd0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_data_o  <= 32'h0;
            resp_rd_o    <= 5'd0;
            resp_err_o   <= 1'b0;
            ram_adr_o    <= 32'h0;
            ram_we_o     <= 1'b0;
            ram_wdata_o  <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q        <= req_op_i;
                        off_q       <= req_addr_i[1:0];
                        wdata_q     <= req_wdata_i[15:0];
                        rd_q        <= req_rd_i;
                        req_ready_o <= 1'b0;
                        if (req_err) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_data_o  <= 32'h0;
                            resp_rd_o    <= req_rd_i;
                        end else if (req_op_i == OP_SW) begin
                            state       <= WR;
                            ram_adr_o   <= {2'b00, req_addr_i[31:2]};
                            ram_wdata_o <= req_wdata_i;
                            ram_we_o    <= 1'b1;
                        end else begin
                            state     <= RD1;
                            ram_adr_o <= {2'b00, req_addr_i[31:2]};
                            ram_we_o  <= 1'b0;
                        end
                    end
                end
                RD1: begin
                    state <= RD2;
                end
                RD2: begin
                    if (is_load_q) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_data_o  <= load_value;
                        resp_rd_o    <= rd_q;
                    end else begin
                        state       <= WR;
                        ram_wdata_o <= merged_word;
                        ram_we_o    <= 1'b1;
                    end
                end
                WR: begin
                    state        <= RESP;
                    ram_we_o     <= 1'b0;
                    resp_valid_o <= 1'b1;
                    resp_err_o   <= 1'b0;
                    resp_data_o  <= 32'h0;
                    resp_rd_o    <= rd_q;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    ram_we_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dlx_mem_access_unit.sv
// ============================================================================
// Module   : tb_dlx_mem_access_unit
// Purpose  : Directed vector bench for dlx_mem_access_unit with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dlx_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_op_i = 3'd0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic [4:0]  req_rd_i = 5'd0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        resp_err_o;
    logic [31:0] ram_adr_o;
    logic        ram_we_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    dlx_mem_access_unit #(.DEPTH_WORDS(64)) dut (
        .clk_i        (clk_i),
        .reset_n      (reset_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rd_i     (req_rd_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_rd_o    (resp_rd_o),
        .resp_err_o   (resp_err_o),
        .ram_adr_o    (ram_adr_o),
        .ram_we_o     (ram_we_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_rdata_i  (ram_rdata_i)
    );

    // Word RAM with registered read; preloaded once at start of simulation.
    logic [31:0] mem [64];
    logic        load_mem = 1'b1;
    always @(posedge clk_i) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h01020304;
            mem[5] <= 32'h8899AABB;
            mem[8] <= 32'h11223344;
        end else if (ram_we_o) begin
            mem[ram_adr_o[5:0]] <= ram_wdata_o;
        end
        ram_rdata_i <= mem[ram_adr_o[5:0]];
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_wadr;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        int          wecnt;
        logic [31:0] wadr;
        logic [31:0] wword;
        req_op_i    = v.op;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        req_rd_i    = v.rd;
        req_valid_i = 1'b1;
        wecnt = 0;
        wadr  = 32'h0;
        wword = 32'h0;
        tick();
        req_valid_i = 1'b0;
        n = 1;
        if (ram_we_o) begin wecnt++; wadr = ram_adr_o; wword = ram_wdata_o; end
        while (!resp_valid_o && n < 12) begin
            tick();
            n++;
            if (ram_we_o) begin wecnt++; wadr = ram_adr_o; wword = ram_wdata_o; end
        end
        chk("latency", idx, n, v.exp_lat);
        chk("resp_valid", idx, {31'h0, resp_valid_o}, 32'h1);
        chk("resp_data", idx, resp_data_o, v.exp_data);
        chk("resp_err", idx, {31'h0, resp_err_o}, {31'h0, v.exp_err});
        chk("resp_rd", idx, {27'h0, resp_rd_o}, {27'h0, v.rd});
        chk("we_pulses", idx, wecnt, v.exp_we);
        if (v.exp_we != 0) begin
            chk("ram_adr", idx, wadr, v.exp_wadr);
            chk("ram_wdata", idx, wword, v.exp_wword);
        end
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        chk("valid_drop", idx, {31'h0, resp_valid_o}, 32'h0);
        chk("ready_back", idx, {31'h0, req_ready_o}, 32'h1);
    endtask

    initial begin
        vec_t v;
        //            op      addr          wdata          rd     exp_data       err  lat we  wadr  wword
        vecs[0]  = '{3'b000, 32'h14,  32'h0,         5'd1,  32'hFFFFFF88, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[1]  = '{3'b001, 32'h17,  32'h0,         5'd2,  32'h000000BB, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[2]  = '{3'b010, 32'h16,  32'h0,         5'd3,  32'hFFFFAABB, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[3]  = '{3'b011, 32'h14,  32'h0,         5'd4,  32'h00008899, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[4]  = '{3'b100, 32'h14,  32'h0,         5'd5,  32'h8899AABB, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[5]  = '{3'b101, 32'h15,  32'h00000012,  5'd6,  32'h0,        1'b0, 4, 1, 32'd5, 32'h8812AABB};
        vecs[6]  = '{3'b100, 32'h14,  32'h0,         5'd7,  32'h8812AABB, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[7]  = '{3'b111, 32'h20,  32'hDEADBEEF,  5'd8,  32'h0,        1'b0, 2, 1, 32'd8, 32'hDEADBEEF};
        vecs[8]  = '{3'b100, 32'h20,  32'h0,         5'd9,  32'hDEADBEEF, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[9]  = '{3'b010, 32'h13,  32'h0,         5'd10, 32'h0,        1'b1, 1, 0, 32'd0, 32'h0};
        vecs[10] = '{3'b100, 32'h22,  32'h0,         5'd11, 32'h0,        1'b1, 1, 0, 32'd0, 32'h0};
        vecs[11] = '{3'b000, 32'h100, 32'h0,         5'd12, 32'h0,        1'b1, 1, 0, 32'd0, 32'h0};
        vecs[12] = '{3'b110, 32'h12,  32'hFFFFCAFE,  5'd13, 32'h0,        1'b0, 4, 1, 32'd4, 32'h0102CAFE};
        vecs[13] = '{3'b011, 32'h12,  32'h0,         5'd14, 32'h0000CAFE, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[14] = '{3'b000, 32'h16,  32'h0,         5'd15, 32'hFFFFFFAA, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[15] = '{3'b001, 32'h15,  32'h0,         5'd16, 32'h00000012, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[16] = '{3'b111, 32'h21,  32'h55555555,  5'd17, 32'h0,        1'b1, 1, 0, 32'd0, 32'h0};
        vecs[17] = '{3'b010, 32'h10,  32'h0,         5'd31, 32'h00000102, 1'b0, 3, 0, 32'd0, 32'h0};
        vecs[18] = '{3'b000, 32'h11,  32'h0,         5'd18, 32'h00000002, 1'b0, 3, 0, 32'd0, 32'h0};

        // Reset with RAM preload
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req_ready", 0, {31'h0, req_ready_o}, 32'h1);
        chk("rst_resp_valid", 0, {31'h0, resp_valid_o}, 32'h0);
        chk("rst_resp_data", 0, resp_data_o, 32'h0);
        chk("rst_resp_rd", 0, {27'h0, resp_rd_o}, 32'h0);
        chk("rst_resp_err", 0, {31'h0, resp_err_o}, 32'h0);
        chk("rst_ram_adr", 0, ram_adr_o, 32'h0);
        chk("rst_ram_we", 0, {31'h0, ram_we_o}, 32'h0);
        chk("rst_ram_wdata", 0, ram_wdata_o, 32'h0);
        load_mem = 1'b0;
        @(negedge clk_i);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

        chk("mem5_after", 0, mem[5], 32'h8812AABB);
        chk("mem8_after", 0, mem[8], 32'hDEADBEEF);
        chk("mem4_after", 0, mem[4], 32'h0102CAFE);

        // Backpressure: response frozen and a competing request ignored
        begin
            int n;
            req_op_i = 3'b100; req_addr_i = 32'h20; req_rd_i = 5'd21; req_wdata_i = 32'h0;
            req_valid_i = 1'b1;
            tick();
            req_op_i = 3'b111; req_addr_i = 32'h20; req_wdata_i = 32'h0BADF00D; req_rd_i = 5'd22;
            n = 1;
            while (!resp_valid_o && n < 12) begin tick(); n++; end
            chk("bp_latency", 0, n, 3);
            for (int c = 0; c < 5; c++) begin
                tick();
                chk("bp_valid", c, {31'h0, resp_valid_o}, 32'h1);
                chk("bp_data", c, resp_data_o, 32'hDEADBEEF);
                chk("bp_rd", c, {27'h0, resp_rd_o}, 32'd21);
                chk("bp_req_ready", c, {31'h0, req_ready_o}, 32'h0);
                chk("bp_we", c, {31'h0, ram_we_o}, 32'h0);
            end
            req_valid_i = 1'b0;
            resp_ready_i = 1'b1;
            tick();
            resp_ready_i = 1'b0;
            chk("bp_release", 0, {31'h0, resp_valid_o}, 32'h0);
            tick();
            chk("bp_mem8", 0, mem[8], 32'hDEADBEEF);
        end

        // Reset during the write cycle of an SH
        begin
            req_op_i = 3'b110; req_addr_i = 32'h10; req_wdata_i = 32'h0000BEEF; req_rd_i = 5'd23;
            req_valid_i = 1'b1;
            tick();
            req_valid_i = 1'b0;
            tick();
            tick();
            chk("rmw_we_high", 0, {31'h0, ram_we_o}, 32'h1);
            chk("rmw_wdata", 0, ram_wdata_o, 32'hBEEFCAFE);
            reset_n = 1'b0;
            #1;
            chk("rst_we_drop", 0, {31'h0, ram_we_o}, 32'h0);
            chk("rst_ready", 0, {31'h0, req_ready_o}, 32'h1);
            repeat (2) @(posedge clk_i);
            @(negedge clk_i);
            reset_n = 1'b1;
            tick();
            chk("rst_mem4", 0, mem[4], 32'h0102CAFE);
            chk("rst_no_resp", 0, {31'h0, resp_valid_o}, 32'h0);
            chk("rst_idle_ready", 0, {31'h0, req_ready_o}, 32'h1);
            v = '{3'b100, 32'h10, 32'h0, 5'd24, 32'h0102CAFE, 1'b0, 3, 0, 32'd0, 32'h0};
            run_vec(99, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dlx_mem_access_unit.md
# dlx_mem_access_unit

MEM-stage load/store unit placed directly upstream of the word-addressed data RAM in the DLX pipeline. It accepts one memory request at a time from the EX/MEM register. It converts DLX byte addresses and sub-word operations (LB/LBU/LH/LHU/LW/SB/SH/SW) into word-wide RAM reads and writes, using read-modify-write for partial stores. Load data is returned sign- or zero-extended, tagged with its destination register, to the writeback stage.

## Interface
- DEPTH_WORDS, 64, number of 32-bit RAM words; word index ≥ DEPTH_WORDS is out of range
- clk_i  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit idle, can accept
- req_op_i  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-justified (SB uses [7:0], SH uses [15:0])
- req_rd_i  in  5  destination register tag
- resp_valid_o  out  1  response held until resp_ready_i
- resp_ready_i  in  1  consumer accepts response
- resp_data_o  out  32  extended load data; 0 for stores and errors
- resp_rd_o  out  5  tag of the request being answered
- resp_err_o  out  1  misaligned or out-of-range access
- ram_adr_o  out  32  word index = req_addr_i[31:2], zero-extended
- ram_we_o  out  1  RAM write enable
- ram_wdata_o  out  32  word to write
- ram_rdata_i  in  32  RAM registered read data; reflects the ram_adr_o sampled on the previous edge

## Operation
- Byte order is big-endian. Byte offset 0 = bits [31:24] and offset 3 = bits [7:0]. Halfword offset 0 = [31:16] and offset 2 = [15:0].
- States are IDLE, RD1, RD2, WR, RESP. All outputs are registered.
- req_ready_o = (state == IDLE). A request is accepted on an edge where req_valid_i and req_ready_o are both 1. All request fields are latched on that edge.
- Error check at accept:
  - LH/LHU/SH with addr[0]=1 is an error.
  - LW/SW with addr[1:0]≠0 is an error.
  - Word index ≥ DEPTH_WORDS is an error.
  - On error, the unit goes IDLE→RESP with resp_err_o=1 and resp_data_o=0. ram_we_o is never asserted.
- Loads and SB/SH:
  - IDLE→RD1: drive ram_adr_o with ram_we_o=0.
  - RD1→RD2: the RAM samples the address.
  - On the RD2 edge, the unit samples ram_rdata_i.
  - Loads: extract the lane, sign-extend for LB/LH or zero-extend for LBU/LHU/LW, and go to RESP.
  - SB/SH: merge req_wdata_i into the addressed lane and keep the other lanes unchanged. Set ram_wdata_o=merged and ram_we_o=1, then go to WR.
- SW skips the read. IDLE→WR with ram_wdata_o=req_wdata_i and ram_we_o=1.
- WR→RESP: the RAM commits the write on this edge. ram_we_o returns to 0 and resp_data_o=0.
- RESP: resp_valid_o=1 with stable data, rd and err. On the edge where resp_ready_i=1, go RESP→IDLE and drop resp_valid_o. A new request is accepted no earlier than the following edge.
- ram_adr_o holds its last value whenever the state is not RD1/RD2/WR.

## Timing
- Reset values: state IDLE, req_ready_o 1, resp_valid_o 0, resp_data_o 0, resp_rd_o 0, resp_err_o 0, ram_adr_o 0, ram_we_o 0, ram_wdata_o 0.
- Latency, counted from the accept edge A to the edge that raises resp_valid_o:
  - error: 1 edge
  - SW: 2 edges (write at A+1)
  - loads: 3 edges (read data sampled at A+2)
  - SB/SH: 4 edges (read at A+2, write at A+3)
- ram_we_o is high for exactly one cycle per store and never during loads or errors.
- resp_valid_o stays high indefinitely while resp_ready_i=0. All resp_* outputs are frozen during that time.
- Reset asserted mid-operation immediately clears ram_we_o, so no write commits. The request is dropped with no response, and the unit returns to IDLE.
- req_valid_i is ignored in every state except IDLE.

## Test plan
- After reset: all outputs at their reset values. RAM preloaded word 5 = 0x8899AABB. LB at addr 0x14 → after 3 edges resp_data 0xFFFFFF88, err 0. LBU at 0x17 → 0x000000BB.
- LH at 0x16 → 0xFFFFAABB. LHU at 0x14 → 0x00008899. LW at 0x14 → 0x8899AABB, with resp_rd matching req_rd.
- SB at 0x15 with wdata 0x12 → exactly one ram_we_o pulse with ram_wdata 0x8812AABB at word 5, ack after 4 edges. A subsequent LW at 0x14 returns 0x8812AABB.
- SW at 0x20 with data 0xDEADBEEF → ram_we_o high one cycle at word 8, ack after 2 edges. LH at 0x13, LW at 0x22, and LB at byte 0x100 (word 64) → each returns err 1, data 0, and the RAM is untouched.
- Hold resp_ready_i=0 for 5 cycles → resp_valid_o and resp_data_o stay stable, req_ready_o stays 0, and a concurrent req_valid_i is ignored.
- Assert reset_n low during WR of an SH → ram_we_o drops at once, RAM word unchanged, no response; unit is IDLE with req_ready_o=1 after release.
